// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer stages: Gray conversion and
// default synchroniser depth.
package fifo_pkg;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned PTR_MAX_W       = 32;

  // Callers zero-extend their pointer to PTR_MAX_W and truncate the result
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Resettable flop chain that brings a Gray-coded pointer into the local clock domain.
module gray_ptr_sync #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] rq_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        rq_q[k] <= '0;
      end
    end else begin
      rq_q[0] <= d_i;
      for (int k = 1; k < STAGES; k++) begin
        rq_q[k] <= rq_q[k-1];
      end
    end
  end

  assign q_o = rq_q[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full flags and fill level of the dual-clock FIFO.
// ADDR_W must be at least 2.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rptr_gray_async,
  output logic              wr_accept,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wlevel
);

  localparam int unsigned PtrW = ADDR_W + 1;

  logic [ADDR_W:0] wbin_q, wbin_d;
  logic [ADDR_W:0] wgray_q, wgray_d;
  logic [ADDR_W:0] wlevel_q, wlevel_d;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic [ADDR_W:0] rsync;
  logic [ADDR_W:0] rbin;

  gray_ptr_sync #(
    .WIDTH  (PtrW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rptr_gray_async),
    .q_o (rsync)
  );

  assign wr_accept = wr_en & ~full_q;

  always_comb begin
    rbin     = PtrW'(gray2bin(PTR_MAX_W'(rsync)));
    wbin_d   = wbin_q + PtrW'(wr_accept);
    wgray_d  = PtrW'(bin2gray(PTR_MAX_W'(wbin_d)));
    // Full when the write pointer has lapped the read pointer once: top two Gray bits differ
    full_d   = (wgray_d == {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]});
    wlevel_d = wbin_d - rbin;
    afull_d  = (32'(wlevel_d) >= AFULL_THRESH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

  assign waddr       = wbin_q[ADDR_W-1:0];
  assign wptr_gray   = wgray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wlevel      = wlevel_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full at depth 4, almost-full threshold 3.
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] rptr_gray_async;
  logic       wr_accept;
  logic [1:0] waddr;
  logic [2:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [2:0] wlevel;

  fifo_wptr_full #(
    .ADDR_W       (2),
    .SYNC_STAGES  (2),
    .AFULL_THRESH (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .rptr_gray_async (rptr_gray_async),
    .wr_accept       (wr_accept),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .full            (full),
    .almost_full     (almost_full),
    .wlevel          (wlevel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] gray;
    logic       full;
    logic       afull;
    logic [2:0] level;
    logic [1:0] waddr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference state: write pointer, two-stage read-pointer pipe, full flag
  int   m_wbin = 0;
  int   m_rq0  = 0;
  int   m_rq1  = 0;
  logic m_full = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & 7;
  endfunction

  function automatic int from_gray(input int g);
    int b;
    b = 0;
    for (int i = 2; i >= 0; i--) begin
      b[i] = b[(i + 1) % 32] ^ g[i];
    end
    b[3] = 1'b0;
    return b & 7;
  endfunction

  task automatic step(input logic we, input logic r, input logic [2:0] rp);
    exp_t e;
    exp_t got;
    int   acc;
    int   nb;
    int   lvl;
    @(negedge clk);
    rst             = r;
    wr_en           = we;
    rptr_gray_async = rp;
    #1;
    check("wr_accept", 32'(wr_accept), 32'(we & ~m_full));
    acc = (we && !m_full) ? 1 : 0;
    e   = '0;
    if (r) begin
      m_wbin = 0;
      m_rq0  = 0;
      m_rq1  = 0;
      m_full = 1'b0;
    end else begin
      nb      = (m_wbin + acc) % 8;
      lvl     = (nb - from_gray(m_rq1) + 8) % 8;
      m_rq1   = m_rq0;
      m_rq0   = int'(rp);
      m_wbin  = nb;
      m_full  = (lvl == 4);
      e.gray  = 3'(to_gray(nb));
      e.full  = (lvl == 4);
      e.afull = (lvl >= 3);
      e.level = 3'(lvl);
      e.waddr = 2'(nb % 4);
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("wptr_gray", 32'(wptr_gray), 32'(got.gray));
    check("full", 32'(full), 32'(got.full));
    check("almost_full", 32'(almost_full), 32'(got.afull));
    check("wlevel", 32'(wlevel), 32'(got.level));
    check("waddr", 32'(waddr), 32'(got.waddr));
  endtask

  initial begin
    logic [2:0] fill_gray [4];
    logic [2:0] prev;
    logic       seen_wrap;
    int         rd_bin;

    fill_gray[0] = 3'b001;
    fill_gray[1] = 3'b011;
    fill_gray[2] = 3'b010;
    fill_gray[3] = 3'b110;
    rst = 1'b1;
    wr_en = 1'b0;
    rptr_gray_async = '0;

    // Reset held two cycles with writes requested
    step(1'b1, 1'b1, 3'd0);
    step(1'b1, 1'b1, 3'd0);
    check("rst_outputs", 32'({wptr_gray, full, almost_full, wlevel, waddr}), 32'd0);

    // Fill to full, then one refused write
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 3'd0);
      check("fill_gray", 32'(wptr_gray), 32'(fill_gray[i]));
      check("fill_level", 32'(wlevel), 32'(i + 1));
      check("fill_afull", 32'(almost_full), 32'(i >= 2));
      check("fill_full", 32'(full), 32'(i == 3));
    end
    step(1'b1, 1'b0, 3'd0);
    check("full_hold_gray", 32'(wptr_gray), 32'b110);

    // One read becomes visible on the third edge
    step(1'b0, 1'b0, 3'b001);
    check("drain_e1_full", 32'(full), 32'd1);
    step(1'b0, 1'b0, 3'b001);
    check("drain_e2_full", 32'(full), 32'd1);
    step(1'b0, 1'b0, 3'b001);
    check("drain_e3_full", 32'(full), 32'd0);
    check("drain_e3_level", 32'(wlevel), 32'd3);
    step(1'b1, 1'b0, 3'b001);
    check("refill_full", 32'(full), 32'd1);

    // Concurrent writes and reads across pointer wrap
    rd_bin = 1;
    seen_wrap = 1'b0;
    for (int i = 0; i < 14; i++) begin
      prev = wptr_gray;
      if (rd_bin != m_wbin) rd_bin = (rd_bin + 1) % 8;
      step(1'b1, 1'b0, 3'(to_gray(rd_bin)));
      if (prev != wptr_gray) check("wrap_onebit", 32'($countones(prev ^ wptr_gray)), 32'd1);
      check("wrap_level_max", 32'(wlevel <= 3'd4), 32'd1);
      if (prev == 3'b100 && wptr_gray == 3'b000) seen_wrap = 1'b1;
    end
    check("wrap_seen", 32'(seen_wrap), 32'd1);

    // Simultaneous write and read step at level 2
    step(1'b0, 1'b1, 3'd0);
    step(1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0);
    check("simul_pre_level", 32'(wlevel), 32'd2);
    step(1'b1, 1'b0, 3'b001);
    check("simul_full", 32'(full), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'b001);
      check("simul_full", 32'(full), 32'd0);
    end
    check("simul_level", 32'(wlevel), 32'd2);

    // Mid-operation reset
    step(1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0);
    check("midrst_pre_level", 32'(wlevel), 32'd3);
    step(1'b1, 1'b1, 3'd0);
    check("midrst_outputs", 32'({wptr_gray, full, almost_full, wlevel, waddr}), 32'd0);
    step(1'b1, 1'b0, 3'd0);
    check("midrst_first_gray", 32'(wptr_gray), 32'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
